// File: rtl/lap_timer_controller.sv
// Lap timer sequencer: conditions both gate sensors and drives start/stop of the
// shared millisecond timer, then publishes the run result and best time.

module lap_timer_gate #(
  parameter int DEBOUNCE_MS = 5
) (
  input  logic clk_1khz,
  input  logic reset_n,
  input  logic raw_i,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic          s1_q, s2_q, deb_q;
  logic [CW-1:0] cnt_q;
  logic          differ, flip;

  assign differ = s2_q ^ deb_q;
  assign flip   = differ && (cnt_q == CW'(DEBOUNCE_MS - 1));
  // Rise is flagged in the cycle the debounced level flips, so both gates share one latency.
  assign rise_o = flip & s2_q;

  always_ff @(posedge clk_1khz or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      if (!differ) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q <= '0;
        deb_q <= s2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

module lap_timer_controller #(
  parameter int DEBOUNCE_MS = 5,
  parameter int LOCKOUT_MS  = 200,
  parameter int TIMEOUT_MS  = 2000,
  parameter int TIME_W      = 12
) (
  input  logic              clk_1khz,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              clear_best,
  input  logic              gate_start_raw,
  input  logic              gate_finish_raw,
  output logic              timer_start,
  output logic              timer_stop,
  input  logic [TIME_W-1:0] time_ms,
  input  logic              timing_active,
  output logic [TIME_W-1:0] result_ms,
  output logic              result_valid,
  output logic [TIME_W-1:0] best_ms,
  output logic              best_valid,
  output logic              run_timeout,
  output logic [2:0]        state,
  output logic              busy
);
  localparam int NUM_GATES = 2;
  localparam int LW        = $clog2(LOCKOUT_MS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_STARTING = 3'd2,
    S_RUNNING  = 3'd3,
    S_STOPPING = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    C_ABORT   = 2'd0,
    C_FINISH  = 2'd1,
    C_TIMEOUT = 2'd2
  } cause_e;

  logic [NUM_GATES-1:0] raw_vec, rise_vec;
  logic                 start_rise, finish_rise;

  assign raw_vec     = {gate_finish_raw, gate_start_raw};
  assign start_rise  = rise_vec[0];
  assign finish_rise = rise_vec[1];

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    lap_timer_gate #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_gate (
      .clk_1khz (clk_1khz),
      .reset_n  (reset_n),
      .raw_i    (raw_vec[g]),
      .rise_o   (rise_vec[g])
    );
  end

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic              tstart_q, tstart_d, tstop_q, tstop_d;
  logic [TIME_W-1:0] result_q, result_d, best_q, best_d;
  logic              rv_q, rv_d, bv_q, bv_d, rto_q, rto_d;

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    lock_d   = lock_q;
    tstart_d = 1'b0;
    tstop_d  = 1'b0;
    result_d = result_q;
    rv_d     = 1'b0;
    best_d   = best_q;
    bv_d     = bv_q;
    rto_d    = 1'b0;

    if (clear_best && !rv_q) begin
      best_d = '0;
      bv_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start_rise) begin
          tstart_d = 1'b1;
          state_d  = S_STARTING;
        end
      end
      S_STARTING: begin
        if (abort) begin
          tstop_d = 1'b1;
          cause_d = C_ABORT;
          state_d = S_STOPPING;
        end else if (timing_active) begin
          lock_d  = '0;
          state_d = S_RUNNING;
        end
      end
      S_RUNNING: begin
        if (lock_q != LW'(LOCKOUT_MS)) lock_d = lock_q + LW'(1);
        if (abort) begin
          tstop_d = 1'b1;
          cause_d = C_ABORT;
          state_d = S_STOPPING;
        end else if (finish_rise && lock_q == LW'(LOCKOUT_MS)) begin
          tstop_d = 1'b1;
          cause_d = C_FINISH;
          state_d = S_STOPPING;
        end else if (time_ms >= TIME_W'(TIMEOUT_MS)) begin
          tstop_d = 1'b1;
          cause_d = C_TIMEOUT;
          state_d = S_STOPPING;
        end
      end
      S_STOPPING: begin
        // time_ms is only final once the timer has dropped timing_active.
        if (!timing_active) begin
          state_d = S_DONE;
          case (cause_q)
            C_FINISH: begin
              result_d = time_ms;
              rv_d     = 1'b1;
              if (!bv_q || time_ms < best_q) begin
                best_d = time_ms;
                bv_d   = 1'b1;
              end
            end
            C_TIMEOUT: rto_d = 1'b1;
            default: ;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1khz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cause_q  <= C_ABORT;
      lock_q   <= '0;
      tstart_q <= 1'b0;
      tstop_q  <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
      best_q   <= '0;
      bv_q     <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      lock_q   <= lock_d;
      tstart_q <= tstart_d;
      tstop_q  <= tstop_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      best_q   <= best_d;
      bv_q     <= bv_d;
      rto_q    <= rto_d;
    end
  end

  assign timer_start  = tstart_q;
  assign timer_stop   = tstop_q;
  assign result_ms    = result_q;
  assign result_valid = rv_q;
  assign best_ms      = best_q;
  assign best_valid   = bv_q;
  assign run_timeout  = rto_q;
  assign state        = state_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_lap_timer_controller.sv
// Bench for lap_timer_controller with a behavioural millisecond timer attached.

module tb_lap_timer_controller;
  localparam int D = 2, L = 10, T = 100, W = 12;

  logic clk_1khz = 1'b0, reset_n = 1'b0;
  logic arm = 0, abort = 0, clear_best = 0, gate_start_raw = 0, gate_finish_raw = 0;
  logic timer_start, timer_stop, result_valid, best_valid, run_timeout, busy;
  logic [W-1:0] result_ms, best_ms;
  logic [2:0] state;
  logic t_act;
  logic [W-1:0] t_ms;

  lap_timer_controller #(.DEBOUNCE_MS(D), .LOCKOUT_MS(L), .TIMEOUT_MS(T), .TIME_W(W)) dut (
    .clk_1khz(clk_1khz), .reset_n(reset_n), .arm(arm), .abort(abort), .clear_best(clear_best),
    .gate_start_raw(gate_start_raw), .gate_finish_raw(gate_finish_raw),
    .timer_start(timer_start), .timer_stop(timer_stop), .time_ms(t_ms), .timing_active(t_act),
    .result_ms(result_ms), .result_valid(result_valid), .best_ms(best_ms), .best_valid(best_valid),
    .run_timeout(run_timeout), .state(state), .busy(busy));

  always #5 clk_1khz = ~clk_1khz;

  // Millisecond timer: start zeroes and runs, stop wins over counting.
  always @(posedge clk_1khz or negedge reset_n) begin
    if (!reset_n) begin t_act <= 1'b0; t_ms <= '0; end
    else if (timer_stop) t_act <= 1'b0;
    else if (timer_start && !t_act) begin t_act <= 1'b1; t_ms <= '0; end
    else if (t_act) t_ms <= t_ms + 1'b1;
  end

  int cyc = 0, n_start = 0, n_stop = 0, n_rv = 0, n_rto = 0, start_cyc = 0, stop_cyc = 0;
  int both_err = 0, long_err = 0;
  logic prev_start = 0, prev_stop = 0;
  logic [W-1:0] stop_time = '0;

  always @(negedge clk_1khz) begin
    cyc++;
    if (timer_start) begin n_start++; start_cyc = cyc; end
    if (timer_stop) begin n_stop++; stop_cyc = cyc; stop_time = t_ms; end
    if (result_valid) n_rv++;
    if (run_timeout) n_rto++;
    if (timer_start && timer_stop) both_err++;
    if ((timer_start && prev_start) || (timer_stop && prev_stop)) long_err++;
    prev_start = timer_start;
    prev_stop  = timer_stop;
  end

  int vectors = 0, miscompares = 0;
  logic [W-1:0] exp_res = '0, exp_best = '0;
  logic exp_bv = 1'b0;
  int s0, p0, r0, t0;

  // Reference: a finished run measures (raw finish rise - raw start rise) - 1 ms.
  task automatic model_finish(input int sep);
    exp_res = W'(sep - 1);
    if (!exp_bv || exp_res < exp_best) begin exp_best = exp_res; exp_bv = 1'b1; end
  endtask

  task automatic snap();
    s0 = n_start; p0 = n_stop; r0 = n_rv; t0 = n_rto;
  endtask

  task automatic drive_run(input int sep, input int early, input bit do_abort);
    arm = 1; @(negedge clk_1khz); arm = 0;
    repeat (3) @(negedge clk_1khz);
    for (int k = 0; k < sep + 12; k++) begin
      gate_start_raw  = (k < 5);
      gate_finish_raw = (sep > 0 && k >= sep && k < sep + 5) || (early > 0 && k >= early && k < early + 5);
      abort = do_abort && (k == sep + D + 1);
      @(negedge clk_1khz);
    end
    gate_start_raw = 0; gate_finish_raw = 0; abort = 0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && state !== 3'd0; i++) @(negedge clk_1khz);
    @(negedge clk_1khz);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_1khz);
    vectors++; if ({timer_start, timer_stop, result_valid, best_valid, run_timeout, busy} !== 6'b0 || state !== 3'd0 || result_ms !== '0 || best_ms !== '0) begin
      miscompares++; $display("FAIL reset_outputs: st=%0d res=%0d best=%0d flags=%b, required all 0", state, result_ms, best_ms, {timer_start, timer_stop, result_valid, best_valid, run_timeout, busy}); end
    reset_n = 1; @(negedge clk_1khz);
  endtask

  task automatic test_single_run();
    snap(); drive_run(50, 0, 0); wait_idle(50); model_finish(50);
    vectors++; if (stop_cyc - start_cyc != 50) begin miscompares++; $display("FAIL single_gap: %0d, required 50", stop_cyc - start_cyc); end
    vectors++; if (result_ms !== exp_res) begin miscompares++; $display("FAIL single_result: %0d, required %0d", result_ms, exp_res); end
    vectors++; if (n_rv - r0 != 1) begin miscompares++; $display("FAIL single_rv_count: %0d, required 1", n_rv - r0); end
    vectors++; if (best_ms !== exp_best || best_valid !== exp_bv) begin miscompares++; $display("FAIL single_best: %0d/%b, required %0d/%b", best_ms, best_valid, exp_best, exp_bv); end
    vectors++; if (state !== 3'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: st=%0d busy=%b, required 0/0", state, busy); end
  endtask

  task automatic test_lockout();
    snap(); drive_run(40, 5, 0); wait_idle(50); model_finish(40);
    vectors++; if (n_stop - p0 != 1 || stop_cyc - start_cyc != 40) begin miscompares++; $display("FAIL lockout_stop: stops=%0d gap=%0d, required 1/40", n_stop - p0, stop_cyc - start_cyc); end
    vectors++; if (result_ms !== exp_res) begin miscompares++; $display("FAIL lockout_result: %0d, required %0d", result_ms, exp_res); end
    vectors++; if (best_ms !== exp_best) begin miscompares++; $display("FAIL lockout_best: %0d, required %0d", best_ms, exp_best); end
  endtask

  task automatic test_timeout();
    snap(); drive_run(0, 0, 0); wait_idle(300);
    vectors++; if (n_rto - t0 != 1) begin miscompares++; $display("FAIL timeout_pulse: %0d, required 1", n_rto - t0); end
    vectors++; if (n_rv - r0 != 0) begin miscompares++; $display("FAIL timeout_rv: %0d, required 0", n_rv - r0); end
    vectors++; if (n_stop - p0 != 1 || stop_time < W'(T) || stop_time > W'(T + 1)) begin miscompares++; $display("FAIL timeout_stop: stops=%0d time=%0d, required 1 near %0d", n_stop - p0, stop_time, T); end
    vectors++; if (result_ms !== exp_res || best_ms !== exp_best || best_valid !== exp_bv) begin miscompares++; $display("FAIL timeout_hold: res=%0d best=%0d, required %0d/%0d", result_ms, best_ms, exp_res, exp_best); end
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL timeout_idle: %0d, required 0", state); end
  endtask

  task automatic test_glitch_abort();
    snap(); arm = 1; @(negedge clk_1khz); arm = 0; repeat (2) @(negedge clk_1khz);
    for (int i = 0; i < 4; i++) begin
      gate_start_raw = 1; @(negedge clk_1khz); gate_start_raw = 0; repeat (3) @(negedge clk_1khz);
    end
    repeat (6) @(negedge clk_1khz);
    vectors++; if (n_start - s0 != 0 || state !== 3'd1) begin miscompares++; $display("FAIL glitch: starts=%0d st=%0d, required 0/1", n_start - s0, state); end
    abort = 1; @(negedge clk_1khz); abort = 0; @(negedge clk_1khz);
    vectors++; if (state !== 3'd0 || n_stop - p0 != 0) begin miscompares++; $display("FAIL armed_abort: st=%0d stops=%0d, required 0/0", state, n_stop - p0); end
    snap(); drive_run(40, 0, 1); wait_idle(50);
    vectors++; if (n_stop - p0 != 1 || n_start - s0 != 1) begin miscompares++; $display("FAIL abort_pulses: starts=%0d stops=%0d, required 1/1", n_start - s0, n_stop - p0); end
    vectors++; if (n_rv - r0 != 0 || result_ms !== exp_res) begin miscompares++; $display("FAIL abort_result: rv=%0d res=%0d, required 0/%0d", n_rv - r0, result_ms, exp_res); end
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL abort_idle: %0d, required 0", state); end
  endtask

  task automatic test_back_to_back();
    int sep, early;
    for (int r = 0; r < 6; r++) begin
      sep   = (r == 0) ? 30 : (r == 1) ? 70 : $urandom_range(85, 20);
      early = (r < 2 || $urandom_range(1, 0) == 0) ? 0 : $urandom_range(6, 3);
      snap(); drive_run(sep, early, 0); wait_idle(50); model_finish(sep);
      vectors++; if (result_ms !== exp_res || stop_cyc - start_cyc != sep) begin miscompares++; $display("FAIL b2b_result[%0d]: res=%0d gap=%0d, required %0d/%0d", r, result_ms, stop_cyc - start_cyc, exp_res, sep); end
      vectors++; if (best_ms !== exp_best || best_valid !== exp_bv || n_rv - r0 != 1) begin miscompares++; $display("FAIL b2b_best[%0d]: best=%0d rv=%0d, required %0d/1", r, best_ms, n_rv - r0, exp_best); end
    end
  endtask

  task automatic test_clear_best();
    clear_best = 1; @(negedge clk_1khz); clear_best = 0; @(negedge clk_1khz);
    exp_bv = 1'b0; exp_best = '0;
    vectors++; if (best_valid !== 1'b0 || best_ms !== '0) begin miscompares++; $display("FAIL clear_best: %0d/%b, required 0/0", best_ms, best_valid); end
    drive_run(60, 0, 0); wait_idle(50); model_finish(60);
    vectors++; if (best_ms !== exp_best || best_valid !== 1'b1) begin miscompares++; $display("FAIL best_after_clear: %0d/%b, required %0d/1", best_ms, best_valid, exp_best); end
  endtask

  task automatic test_reset_midrun();
    arm = 1; @(negedge clk_1khz); arm = 0; repeat (3) @(negedge clk_1khz);
    gate_start_raw = 1; repeat (5) @(negedge clk_1khz); gate_start_raw = 0;
    repeat (30) @(negedge clk_1khz);
    vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL midrun_running: %0d, required 3", state); end
    #2 reset_n = 0; #1;
    vectors++; if ({timer_start, timer_stop, result_valid, best_valid, run_timeout, busy} !== 6'b0 || state !== 3'd0 || result_ms !== '0 || best_ms !== '0) begin
      miscompares++; $display("FAIL midrun_reset: st=%0d res=%0d best=%0d, required all 0", state, result_ms, best_ms); end
    exp_res = '0; exp_best = '0; exp_bv = 1'b0;
    repeat (2) @(negedge clk_1khz); reset_n = 1; @(negedge clk_1khz);
    snap(); drive_run(45, 0, 0); wait_idle(50); model_finish(45);
    vectors++; if (result_ms !== exp_res || best_ms !== exp_best || n_rv - r0 != 1) begin miscompares++; $display("FAIL post_reset_run: res=%0d best=%0d, required %0d/%0d", result_ms, best_ms, exp_res, exp_best); end
  endtask

  task automatic test_pulse_shape();
    vectors++; if (both_err != 0 || long_err != 0) begin miscompares++; $display("FAIL pulse_shape: overlap=%0d long=%0d, required 0/0", both_err, long_err); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_lockout();
    test_timeout();
    test_glitch_abort();
    test_clear_best();
    test_reset_midrun();
    test_pulse_shape();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
